// File: rtl/clock_time_setter.sv
// rtl/clock_time_setter.sv - key-driven hh:mm:ss entry controller feeding the clock core set port
module clock_time_setter #(
    parameter int TIMEOUT    = 500_000_000,
    parameter int BLINK_DIV  = 12_500_000,
    parameter int SET_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_mode,
    input  logic       key_up,
    input  logic       key_down,
    input  logic [7:0] cur_hh,
    input  logic [7:0] cur_mm,
    input  logic [7:0] cur_ss,
    output logic       set,
    output logic [7:0] s_hh,
    output logic [7:0] s_mm,
    output logic [7:0] s_ss,
    output logic       editing,
    output logic [1:0] field,
    output logic       blink
);

    localparam int TW = $clog2(TIMEOUT);
    localparam int BW = $clog2(BLINK_DIV + 1);
    localparam int SW = $clog2(SET_CYCLES + 1);

    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [SW-1:0] SET_LAST = SW'(SET_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EDIT_HH = 3'd1,
        EDIT_MM = 3'd2,
        EDIT_SS = 3'd3,
        COMMIT  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [BW-1:0] blk_q, blk_d;
    logic [SW-1:0] set_cnt_q, set_cnt_d;
    logic          blink_q, blink_d;
    logic          set_q, set_d;
    logic          editing_q, editing_d;
    logic [1:0]    field_q, field_d;
    logic          field_chg;
    logic          key_any;
    logic          adj;

    function automatic logic [7:0] inc_wrap(input logic [7:0] v, input logic [7:0] max);
        return (v >= max) ? 8'd0 : v + 8'd1;
    endfunction

    function automatic logic [7:0] dec_wrap(input logic [7:0] v, input logic [7:0] max);
        return (v == 8'd0 || v > max) ? max : v - 8'd1;
    endfunction

    assign key_any = key_mode | key_up | key_down;
    assign adj     = key_up ^ key_down;

    always_comb begin
        state_d   = state_q;
        hh_d      = hh_q;
        mm_d      = mm_q;
        ss_d      = ss_q;
        tmo_d     = tmo_q;
        set_cnt_d = set_cnt_q;
        field_chg = 1'b0;

        case (state_q)
            IDLE: begin
                if (key_mode) begin
                    state_d   = EDIT_HH;
                    hh_d      = (cur_hh > 8'd23) ? 8'd0 : cur_hh;
                    mm_d      = (cur_mm > 8'd59) ? 8'd0 : cur_mm;
                    ss_d      = (cur_ss > 8'd59) ? 8'd0 : cur_ss;
                    tmo_d     = '0;
                    field_chg = 1'b1;
                end
            end
            EDIT_HH, EDIT_MM, EDIT_SS: begin
                if (key_mode) begin
                    field_chg = 1'b1;
                    tmo_d     = '0;
                    case (state_q)
                        EDIT_HH: state_d = EDIT_MM;
                        EDIT_MM: state_d = EDIT_SS;
                        default: begin
                            state_d   = COMMIT;
                            set_cnt_d = '0;
                        end
                    endcase
                end else if (key_any) begin
                    // Both up and down together still counts as activity but edits nothing.
                    tmo_d = '0;
                    if (adj) begin
                        case (state_q)
                            EDIT_HH: hh_d = key_up ? inc_wrap(hh_q, 8'd23) : dec_wrap(hh_q, 8'd23);
                            EDIT_MM: mm_d = key_up ? inc_wrap(mm_q, 8'd59) : dec_wrap(mm_q, 8'd59);
                            default: ss_d = key_up ? inc_wrap(ss_q, 8'd59) : dec_wrap(ss_q, 8'd59);
                        endcase
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            COMMIT: begin
                if (set_cnt_q == SET_LAST) begin
                    state_d = IDLE;
                end else begin
                    set_cnt_d = set_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        blk_d     = blk_q;
        blink_d   = blink_q;
        editing_d = 1'b0;
        field_d   = 2'd0;
        set_d     = (state_d == COMMIT);

        case (state_d)
            EDIT_HH: field_d = 2'd1;
            EDIT_MM: field_d = 2'd2;
            EDIT_SS: field_d = 2'd3;
            default: field_d = 2'd0;
        endcase
        editing_d = (field_d != 2'd0);

        // A freshly selected field is shown lit straight away.
        if (!editing_d) begin
            blk_d   = '0;
            blink_d = 1'b0;
        end else if (field_chg) begin
            blk_d   = '0;
            blink_d = 1'b1;
        end else if (blk_q == BLK_LAST) begin
            blk_d   = '0;
            blink_d = ~blink_q;
        end else begin
            blk_d = blk_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            hh_q      <= 8'd0;
            mm_q      <= 8'd0;
            ss_q      <= 8'd0;
            tmo_q     <= '0;
            blk_q     <= '0;
            set_cnt_q <= '0;
            blink_q   <= 1'b0;
            set_q     <= 1'b0;
            editing_q <= 1'b0;
            field_q   <= 2'd0;
        end else begin
            state_q   <= state_d;
            hh_q      <= hh_d;
            mm_q      <= mm_d;
            ss_q      <= ss_d;
            tmo_q     <= tmo_d;
            blk_q     <= blk_d;
            set_cnt_q <= set_cnt_d;
            blink_q   <= blink_d;
            set_q     <= set_d;
            editing_q <= editing_d;
            field_q   <= field_d;
        end
    end

    assign set     = set_q;
    assign s_hh    = hh_q;
    assign s_mm    = mm_q;
    assign s_ss    = ss_q;
    assign editing = editing_q;
    assign field   = field_q;
    assign blink   = blink_q;

endmodule

// File: tb/tb_clock_time_setter.sv
// tb/tb_clock_time_setter.sv - randomized and directed bench for clock_time_setter against a time-entry model
module tb_clock_time_setter;

    localparam int TIMEOUT    = 100;
    localparam int BLINK_DIV  = 4;
    localparam int SET_CYCLES = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_mode = 1'b0, key_up = 1'b0, key_down = 1'b0;
    logic [7:0] cur_hh = 8'd0, cur_mm = 8'd0, cur_ss = 8'd0;
    logic       set, editing, blink;
    logic [7:0] s_hh, s_mm, s_ss;
    logic [1:0] field;

    clock_time_setter #(
        .TIMEOUT   (TIMEOUT),
        .BLINK_DIV (BLINK_DIV),
        .SET_CYCLES(SET_CYCLES)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .key_mode(key_mode),
        .key_up  (key_up),
        .key_down(key_down),
        .cur_hh  (cur_hh),
        .cur_mm  (cur_mm),
        .cur_ss  (cur_ss),
        .set     (set),
        .s_hh    (s_hh),
        .s_mm    (s_mm),
        .s_ss    (s_ss),
        .editing (editing),
        .field   (field),
        .blink   (blink)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: phase 0 idle, 1..3 editing hh/mm/ss, 4 committing.
    int m_phase = 0, m_h = 0, m_m = 0, m_s = 0;
    int m_idle = 0, m_since = 0, m_left = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_h = 0; m_m = 0; m_s = 0;
        m_idle = 0; m_since = 0; m_left = 0;
    endtask

    task automatic model_update(input bit md, input bit up, input bit dn);
        int d;
        case (m_phase)
            0: if (md) begin
                m_phase = 1;
                m_h = (int'(cur_hh) > 23) ? 0 : int'(cur_hh);
                m_m = (int'(cur_mm) > 59) ? 0 : int'(cur_mm);
                m_s = (int'(cur_ss) > 59) ? 0 : int'(cur_ss);
                m_idle = 0; m_since = 0;
            end
            1, 2, 3: begin
                if (md) begin
                    m_phase++;
                    m_idle = 0; m_since = 0;
                    if (m_phase == 4) m_left = SET_CYCLES;
                end else if (up || dn) begin
                    m_idle = 0; m_since++;
                    if (up != dn) begin
                        d = up ? 1 : -1;
                        if (m_phase == 1) m_h = (m_h + d + 24) % 24;
                        else if (m_phase == 2) m_m = (m_m + d + 60) % 60;
                        else m_s = (m_s + d + 60) % 60;
                    end
                end else if (m_idle == TIMEOUT - 1) begin
                    m_phase = 0;
                end else begin
                    m_idle++; m_since++;
                end
            end
            default: begin
                m_left--;
                if (m_left == 0) m_phase = 0;
            end
        endcase
    endtask

    task automatic check_model();
        bit ed;
        ed = (m_phase >= 1 && m_phase <= 3);
        chk("set", 32'(set), 32'(m_phase == 4));
        chk("s_hh", 32'(s_hh), 32'(m_h));
        chk("s_mm", 32'(s_mm), 32'(m_m));
        chk("s_ss", 32'(s_ss), 32'(m_s));
        chk("editing", 32'(editing), 32'(ed));
        chk("field", 32'(field), ed ? 32'(m_phase) : 32'd0);
        chk("blink", 32'(blink), 32'(ed && ((m_since / BLINK_DIV) % 2 == 0)));
    endtask

    task automatic step(input bit md, input bit up, input bit dn);
        @(negedge clk);
        key_mode = md; key_up = up; key_down = dn;
        @(posedge clk);
        #1;
        key_mode = 1'b0; key_up = 1'b0; key_down = 1'b0;
        model_update(md, up, dn);
        check_model();
    endtask

    task automatic capture(input int h, input int m, input int s);
        cur_hh = 8'(h); cur_mm = 8'(m); cur_ss = 8'(s);
        step(1, 0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_set"}, 32'(set), 32'd0);
        chk({tag, "_hh"}, 32'(s_hh), 32'd0);
        chk({tag, "_mm"}, 32'(s_mm), 32'd0);
        chk({tag, "_ss"}, 32'(s_ss), 32'd0);
        chk({tag, "_editing"}, 32'(editing), 32'd0);
        chk({tag, "_field"}, 32'(field), 32'd0);
        chk({tag, "_blink"}, 32'(blink), 32'd0);
    endtask

    task automatic count_to_abort(input string tag);
        int n;
        bit saw_set;
        n = 0; saw_set = 0;
        while (editing === 1'b1 && n < 300) begin
            step(0, 0, 0);
            if (set === 1'b1) saw_set = 1;
            n++;
        end
        chk({tag, "_len"}, 32'(n), 32'd100);
        chk({tag, "_noset"}, 32'(saw_set), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // IDLE ignores up/down.
        step(0, 1, 0);
        step(0, 0, 1);
        chk("idle_field", 32'(field), 32'd0);

        // Capture 12:34:56.
        capture(12, 34, 56);
        chk("cap_field", 32'(field), 32'd1);
        chk("cap_hh", 32'(s_hh), 32'd12);
        chk("cap_mm", 32'(s_mm), 32'd34);
        chk("cap_ss", 32'(s_ss), 32'd56);
        chk("cap_set", 32'(set), 32'd0);

        // Priority: mode beats up; up+down together is no change.
        step(1, 1, 0);
        chk("prio_field", 32'(field), 32'd2);
        chk("prio_hh", 32'(s_hh), 32'd12);
        step(0, 1, 1);
        chk("updn_mm", 32'(s_mm), 32'd34);
        count_to_abort("abort_prio");

        // Wrap at field limits.
        capture(23, 0, 59);
        step(0, 1, 0);
        chk("wrap_hh_up", 32'(s_hh), 32'd0);
        step(0, 0, 1);
        chk("wrap_hh_dn", 32'(s_hh), 32'd23);
        step(1, 0, 0);
        step(0, 0, 1);
        chk("wrap_mm_dn", 32'(s_mm), 32'd59);
        step(1, 0, 0);
        step(0, 1, 0);
        chk("wrap_ss_up", 32'(s_ss), 32'd0);
        count_to_abort("abort_wrap");

        // Full commit 12:34:56 -> 05:00:07.
        capture(12, 34, 56);
        repeat (7) step(0, 0, 1);
        step(1, 0, 0);
        repeat (34) step(0, 0, 1);
        step(1, 0, 0);
        repeat (11) step(0, 1, 0);
        step(1, 0, 0);
        chk("commit_set1", 32'(set), 32'd1);
        chk("commit_hh", 32'(s_hh), 32'd5);
        chk("commit_mm", 32'(s_mm), 32'd0);
        chk("commit_ss", 32'(s_ss), 32'd7);
        step(0, 1, 0);
        chk("commit_set2", 32'(set), 32'd1);
        chk("commit_keys_ignored", 32'(s_ss), 32'd7);
        step(0, 0, 0);
        chk("commit_set3", 32'(set), 32'd0);
        chk("commit_field", 32'(field), 32'd0);

        // Timeout with no keys, then a key on the terminal cycle.
        capture(1, 2, 3);
        count_to_abort("timeout");
        capture(4, 5, 6);
        repeat (99) step(0, 0, 0);
        step(0, 1, 0);
        chk("tmo_key_wins", 32'(editing), 32'd1);
        count_to_abort("timeout_restart");

        // Asynchronous reset in the first commit cycle.
        capture(9, 8, 7);
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        chk("pre_rst_set", 32'(set), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Out-of-range capture loads zero.
        capture(30, 70, 99);
        chk("oor_hh", 32'(s_hh), 32'd0);
        chk("oor_mm", 32'(s_mm), 32'd0);
        chk("oor_ss", 32'(s_ss), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cur_hh = 8'($urandom_range(0, 31));
            cur_mm = 8'($urandom_range(0, 63));
            cur_ss = 8'($urandom_range(0, 63));
            if ($urandom_range(0, 199) == 0) begin
                repeat (105) step(0, 0, 0);
            end else begin
                step($urandom_range(0, 11) == 0, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 3) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
